// File: rtl/mitchell_pkg.sv
// Shared constants, FSM encoding and helpers for the Mitchell multiplier arbiter.
package mitchell_pkg;

    // The multiplier datapath is fixed at 8-bit operands.
    localparam int MUL_SZ   = 8;
    localparam int MUL_LGSZ = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) returns 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mitchell_mul8.sv
// Combinational 8-bit Mitchell log-domain multiplier (approximate product).
module mitchell_mul8
    import mitchell_pkg::*;
(
    input  logic [MUL_SZ-1:0]   x,
    input  logic [MUL_SZ-1:0]   y,
    output logic [2*MUL_SZ-1:0] m
);

    localparam int LG_W = MUL_LGSZ + MUL_SZ - 1;  // {characteristic, mantissa}
    localparam int CS_W = MUL_LGSZ + 1;           // characteristic of the sum

    // Leading-one position becomes the characteristic; the bits below it,
    // left-aligned, become the fractional mantissa.
    function automatic logic [LG_W-1:0] log_approx(input logic [MUL_SZ-1:0] v);
        logic [MUL_LGSZ-1:0] c;
        logic [MUL_SZ-1:0]   norm;
        c = '0;
        for (int i = 0; i < MUL_SZ; i++) begin
            if (v[i]) begin
                c = MUL_LGSZ'(i);
            end
        end
        norm = v << (MUL_LGSZ'(MUL_SZ - 1) - c);
        return {c, norm[MUL_SZ-2:0]};
    endfunction

    logic [LG_W:0]          lg_sum;
    logic [CS_W-1:0]        char_s;
    logic [MUL_SZ-2:0]      mant_s;
    logic [2*MUL_SZ-1:0]    scaled;

    // Add the logs, then take the antilog as (1.mant) shifted by the characteristic.
    always_comb begin
        lg_sum = {1'b0, log_approx(x)} + {1'b0, log_approx(y)};
        char_s = lg_sum[LG_W -: CS_W];
        mant_s = lg_sum[MUL_SZ-2:0];
        scaled = {1'b1, mant_s, {MUL_SZ{1'b0}}} >> (CS_W'(2 * MUL_SZ - 1) - char_s);
        m      = (x == '0 || y == '0) ? '0 : scaled;
    end

endmodule

// File: rtl/mitchell_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, circularly.
module mitchell_rr_arbiter
    import mitchell_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    logic [N_REQ-1:0] masked_req;
    logic [N_REQ-1:0] pick_vec;

    // Requests at or above the pointer get first chance; lower ones wrap around.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
        assign masked_req[gi] = req[gi] & (ID_W'(gi) >= ptr);
    end

    // Lowest set bit of the chosen vector wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        pick_vec  = (|masked_req) ? masked_req : req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/mitchell_mul_arbiter.sv
// Shares one Mitchell multiplier among N_REQ requesters with round-robin
// arbitration; one operation in flight, result returned with the owner's ID.
module mitchell_mul_arbiter
    import mitchell_pkg::*;
#(
    parameter int SZ    = 8,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*SZ-1:0] req_x,
    input  logic [N_REQ*SZ-1:0] req_y,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [2*SZ-1:0]     rsp_m,
    output logic                busy
);

    localparam int ID_W_EXP = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);

    if (SZ != MUL_SZ) begin : g_bad_sz
        $error("mitchell_mul_arbiter: SZ must be %0d", MUL_SZ);
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("mitchell_mul_arbiter: N_REQ must be in 2..8");
    end
    if (ID_W != ID_W_EXP) begin : g_bad_idw
        $error("mitchell_mul_arbiter: ID_W must be %0d", ID_W_EXP);
    end

    state_t             state_reg;
    state_t             state_next;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [SZ-1:0]      op_x_reg;
    logic [SZ-1:0]      op_y_reg;
    logic [ID_W-1:0]    op_id_reg;
    logic               rsp_valid_reg;
    logic [ID_W-1:0]    rsp_id_reg;
    logic [2*SZ-1:0]    rsp_m_reg;

    logic [SZ-1:0]      x_arr [N_REQ];
    logic [SZ-1:0]      y_arr [N_REQ];
    logic [N_REQ-1:0]   grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic [2*SZ-1:0]    mul_m;
    logic [ID_W-1:0]    rr_ptr_next;

    // Unpack the flat operand buses into per-requester lanes.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign x_arr[gi] = req_x[gi*SZ +: SZ];
        assign y_arr[gi] = req_y[gi*SZ +: SZ];
    end

    mitchell_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant_oh),
        .grant_idx (grant_idx)
    );

    mitchell_mul8 u_mul (
        .x (op_x_reg),
        .y (op_y_reg),
        .m (mul_m)
    );

    // The requester after the one just served gets first priority next time.
    assign rr_ptr_next = (op_id_reg == ID_W'(N_REQ - 1)) ? '0 : op_id_reg + ID_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept, compute for one cycle, hold until consumed.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req_valid) state_next = CALC;
            CALC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; grants are only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        busy      = (state_reg != IDLE);
        if (state_reg == IDLE && !rst) begin
            req_ready = grant_oh;
        end
    end

    // Operand capture, result capture and round-robin pointer advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg    <= '0;
            op_x_reg      <= '0;
            op_y_reg      <= '0;
            op_id_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_m_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_valid) begin
                        op_x_reg  <= x_arr[grant_idx];
                        op_y_reg  <= y_arr[grant_idx];
                        op_id_reg <= grant_idx;
                    end
                end
                CALC: begin
                    rsp_m_reg     <= mul_m;
                    rsp_id_reg    <= op_id_reg;
                    rsp_valid_reg <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rr_ptr_reg    <= rr_ptr_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_m     = rsp_m_reg;

endmodule

// File: tb/tb_mitchell_mul_arbiter.sv
// Directed testbench for mitchell_mul_arbiter with hand-computed products.
module tb_mitchell_mul_arbiter;

    localparam int SZ    = 8;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*SZ-1:0] req_x;
    logic [N_REQ*SZ-1:0] req_y;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [2*SZ-1:0]     rsp_m;
    logic                busy;

    int checks = 0;
    int errors = 0;

    mitchell_mul_arbiter #(
        .SZ    (SZ),
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_m     (rsp_m),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int idx, input logic [7:0] x, input logic [7:0] y);
        req_x[idx*SZ +: SZ] = x;
        req_y[idx*SZ +: SZ] = y;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        req_x     = '0;
        req_y     = '0;
        tick();
        tick();
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_flags: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
        checks++;
        if (rsp_m !== 16'd0 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL reset_rsp: m=%0d id=%0d want 0 0", rsp_m, rsp_id);
        end
        req_valid = '0;
        rst       = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        set_op(0, 8'd3, 8'd3);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_calc: ready=%b busy=%b rsp_valid=%b want 0000 1 0", req_ready, busy, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_m !== 16'd8 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL single_rsp: valid=%b m=%0d id=%0d want 1 8 0", rsp_valid, rsp_m, rsp_id);
        end
        $display("txn single: id=%0d m=%0d", rsp_id, rsp_m);
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_done: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_products();
        logic [7:0]  tx [5];
        logic [7:0]  ty [5];
        logic [15:0] tm [5];
        int          idx;
        tx = '{8'd2, 8'd16, 8'd255, 8'd0,   8'd1};
        ty = '{8'd3, 8'd16, 8'd255, 8'd200, 8'd1};
        tm = '{16'd6, 16'd256, 16'd65024, 16'd0, 16'd1};
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idx = k % N_REQ;
            set_op(idx, tx[k], ty[k]);
            req_valid      = '0;
            req_valid[idx] = 1'b1;
            #1;
            checks++;
            if (req_ready !== req_valid) begin
                errors++; $display("FAIL prod_grant[%0d]: got %b want %b", k, req_ready, req_valid);
            end
            tick();
            req_valid = '0;
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_m !== tm[k] || rsp_id !== ID_W'(idx)) begin
                errors++; $display("FAIL prod[%0d] %0d*%0d: valid=%b m=%0d id=%0d want 1 %0d %0d",
                                   k, tx[k], ty[k], rsp_valid, rsp_m, rsp_id, tm[k], idx);
            end
            $display("txn product: %0d*%0d -> %0d id=%0d", tx[k], ty[k], rsp_m, rsp_id);
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_m [4];
        int          exp_id;
        exp_m = '{16'd6, 16'd256, 16'd1, 16'd32};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(0, 8'd2,  8'd3);
        set_op(1, 8'd16, 8'd16);
        set_op(2, 8'd1,  8'd1);
        set_op(3, 8'd4,  8'd8);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % N_REQ;
            #1;
            checks++;
            if (req_ready !== 4'(1 << exp_id)) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, 4'(1 << exp_id));
            end
            tick();
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(exp_id) || rsp_m !== exp_m[exp_id]) begin
                errors++; $display("FAIL rr_rsp[%0d]: valid=%b id=%0d m=%0d want 1 %0d %0d",
                                   k, rsp_valid, rsp_id, rsp_m, exp_id, exp_m[exp_id]);
            end
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL rr_resp_ready[%0d]: got %b want 0000", k, req_ready);
            end
            $display("txn rr: id=%0d m=%0d", rsp_id, rsp_m);
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        // Pointer is 1 here, so requester 2 wins over 3 first.
        rsp_ready = 1'b0;
        set_op(2, 8'd5, 8'd6);
        set_op(3, 8'd4, 8'd8);
        req_valid = 4'b1100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL bp_grant: got %b want 0100", req_ready);
        end
        tick();
        req_valid = 4'b1000;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_m !== 16'd28 || rsp_id !== 2'd2 || req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%b m=%0d id=%0d ready=%b want 1 28 2 0000",
                                   c, rsp_valid, rsp_m, rsp_id, req_ready);
            end
            tick();
        end
        $display("txn backpressure: id=%0d m=%0d", rsp_id, rsp_m);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_accept_cycle: got %b want 0000", req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 4'b1000 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_next_grant: ready=%b rsp_valid=%b want 1000 0", req_ready, rsp_valid);
        end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_m !== 16'd32 || rsp_id !== 2'd3) begin
            errors++; $display("FAIL bp_second: valid=%b m=%0d id=%0d want 1 32 3", rsp_valid, rsp_m, rsp_id);
        end
        $display("txn backpressure: id=%0d m=%0d", rsp_id, rsp_m);
        tick();
    endtask

    task automatic test_reset_mid();
        // Serve requester 1 so the pointer moves to 2, then abort requester 3 in CALC.
        rsp_ready = 1'b1;
        set_op(1, 8'd2, 8'd3);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        set_op(3, 8'd4, 8'd8);
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b1111;
        rst       = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_in_calc: busy=%b want 1", busy);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_reset: rsp_valid=%b busy=%b ready=%b want 0 0 0000", rsp_valid, busy, req_ready);
        end
        checks++;
        if (rsp_m !== 16'd0 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL mid_reset_rsp: m=%0d id=%0d want 0 0", rsp_m, rsp_id);
        end
        rst       = 1'b0;
        req_valid = '0;
        tick();
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_no_spurious: rsp_valid=%b want 0", rsp_valid);
        end
        // A pointer of 0 picks requester 1 out of {1,2}; a stale pointer of 2 would pick 2.
        set_op(2, 8'd5, 8'd6);
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL mid_ptr_cleared: got %b want 0010", req_ready);
        end
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL mid_grant2: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_m !== 16'd28 || rsp_id !== 2'd2) begin
            errors++; $display("FAIL mid_rsp: valid=%b m=%0d id=%0d want 1 28 2", rsp_valid, rsp_m, rsp_id);
        end
        $display("txn after reset: id=%0d m=%0d", rsp_id, rsp_m);
        tick();
    endtask

    task automatic test_withdraw();
        // Pointer is 3; of {0,1} requester 0 wins.
        rsp_ready = 1'b1;
        set_op(0, 8'd3, 8'd5);
        set_op(1, 8'd7, 8'd7);
        req_valid = 4'b0011;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL wd_grant: got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_m !== 16'd14 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL wd_rsp: valid=%b m=%0d id=%0d want 1 14 0", rsp_valid, rsp_m, rsp_id);
        end
        $display("txn withdraw: id=%0d m=%0d", rsp_id, rsp_m);
        tick();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
                errors++; $display("FAIL wd_quiet[%0d]: rsp_valid=%b busy=%b ready=%b want 0 0 0000",
                                   c, rsp_valid, busy, req_ready);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_products();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_withdraw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
